regfile_sb: RTL and testbench
=============================

// Module: regfile_sb
// PURPOSE
//  Parametrised register file for the simple processor datapath: NREG-1 general registers
//  R1..R(NREG-1), two combinational read buses (A/B) and one clocked write port.
//  Select value 0 is not a register: it routes external DIN onto the bus.
//  Adds write-through forwarding and a per-register busy scoreboard so the microsequencer
//  can stall on operands still owed by multi-cycle operations.
// PARAMETERS
//  DW    16  data width of DIN, RIN, ABUS, BBUS and every register
//  NREG  8   select space size; registers 1..NREG-1 exist, index 0 = DIN; power of 2, >=2
//  SW    3   select width, = log2(NREG)
// PORTS
//  CLK    in   1    clock; all state updates on rising edge
//  RST    in   1    synchronous active-high reset
//  ASEL   in   SW   A-bus read select (0 = DIN)
//  BSEL   in   SW   B-bus read select (0 = DIN)
//  DIN    in   DW   external data, driven on a bus whose select is 0
//  DSEL   in   SW   write destination select (0 = no write)
//  WEN    in   1    write enable; RIN written to R[DSEL] when WEN=1 and DSEL!=0
//  RIN    in   DW   write data
//  RSV    in   1    reserve: mark R[RSEL] busy (result pending)
//  RSEL   in   SW   register to reserve (0 = no-op)
//  ABUS   out  DW   A read data
//  BBUS   out  DW   B read data
//  ABUSY  out  1    1 = A operand not valid (R[ASEL] busy and not being written this cycle)
//  BBUSY  out  1    same for B
//  STALL  out  1    ABUSY | BBUSY
// BEHAVIOUR
//  State: R[1..NREG-1] (DW each), busy[1..NREG-1]. No state for index 0.
//  Reset: RST=1 at a rising edge -> all R=0, all busy=0; WEN/RSV in that cycle ignored.
//   Reset mid-operation (busy bits set) discards reservations; no write is replayed.
//  Outputs are combinational from selects/DIN/RIN/state; after reset with all selects=0:
//   ABUS=BBUS=DIN, ABUSY=BBUSY=STALL=0. Nonzero select after reset reads 0.
//  Write: WEN=1, DSEL!=0, RST=0 -> R[DSEL]<=RIN at edge; busy[DSEL]<=0.
//   WEN=1 with DSEL=0: no state change. WEN=0: DSEL ignored.
//  Read (A shown, B identical, ports independent, same register on both allowed):
//   ASEL==0 -> ABUS=DIN, ABUSY=0.
//   else if WEN & DSEL==ASEL -> ABUS=RIN (forwarding, zero-latency), ABUSY=0.
//   else ABUS=R[ASEL], ABUSY=busy[ASEL].
//  Forwarding is combinational only; RST does not gate it.
//  Reserve: RSV=1, RSEL!=0, RST=0 -> busy[RSEL]<=1 at edge. RSEL=0 ignored.
//  Simultaneous write and reserve, same register: write data lands AND busy ends 1
//   (reserve wins: the new reservation is for a later result). Different registers: both apply.
//  Reserve of an already-busy register: stays busy (no count, single outstanding result).
//  Write to a non-busy register is legal (plain write).
//  Latency: write visible on buses same cycle (forward) and from next cycle via R.
//  No X on outputs for any select value; all selects in range by construction.
// TESTING
//  1 RST=1 one edge, then ASEL=3,BSEL=0,DIN=16'hBEEF -> ABUS=0,BBUS=BEEF,STALL=0.
//  2 WEN=1,DSEL=5,RIN=16'h1234, ASEL=5 same cycle -> ABUS=1234 (forward); next cycle WEN=0 -> ABUS=1234 from R5.
//  3 WEN=1,DSEL=0,RIN=16'hFFFF -> no register changes; ASEL=0 still shows DIN; sweep R1..R7 unchanged.
//  4 RSV=1,RSEL=2; next cycle ASEL=2 -> ABUSY=1,STALL=1; then WEN=1,DSEL=2,RIN=16'h00AA -> ABUSY=0,ABUS=00AA same cycle; busy[2]=0 after edge.
//  5 busy[4]=1; same cycle WEN=1,DSEL=4,RIN=16'h0F0F and RSV=1,RSEL=4 -> after edge R4=0F0F, BSEL=4 gives BBUSY=1.
//  6 R1=16'h5555, busy[1]=1, assert RST one edge mid-stall -> R1=0, ABUSY=0 for ASEL=1; WEN same cycle as RST had no effect.

Source files
------------

// File: rtl/regfile_sb.sv
// -----------------------------------------------------------------------------
// regfile_sb -- register file with write-through forwarding and busy scoreboard
//
// Purpose:
//   NREG-1 general registers R1..R(NREG-1) for the simple processor datapath.
//   Two combinational read buses (A/B) and one clocked write port. Select 0 is
//   not a register: it routes DIN onto the bus. A per-register busy bit lets
//   the microsequencer stall on operands still owed by multi-cycle operations.
//
// Ports:
//   CLK            clock, all state updates on the rising edge
//   RST            synchronous active-high reset (clears data and busy bits)
//   ASEL / BSEL    read selects for the A / B bus (0 = DIN)
//   DIN            external data, shown on a bus whose select is 0
//   DSEL, WEN, RIN write destination (0 = no write), enable, data
//   RSV, RSEL      reserve request: mark R[RSEL] busy (RSEL 0 = no-op)
//   ABUS / BBUS    read data
//   ABUSY / BBUSY  operand not yet valid (busy and not being written now)
//   STALL          ABUSY | BBUSY
// -----------------------------------------------------------------------------
module regfile_sb #(
  parameter int DW   = 16,
  parameter int NREG = 8,
  parameter int SW   = 3
) (
  input  logic          CLK,
  input  logic          RST,
  input  logic [SW-1:0] ASEL,
  input  logic [SW-1:0] BSEL,
  input  logic [DW-1:0] DIN,
  input  logic [SW-1:0] DSEL,
  input  logic          WEN,
  input  logic [DW-1:0] RIN,
  input  logic          RSV,
  input  logic [SW-1:0] RSEL,
  output logic [DW-1:0] ABUS,
  output logic [DW-1:0] BBUS,
  output logic          ABUSY,
  output logic          BBUSY,
  output logic          STALL
);

  // Flattened view of the register state for the read muxes. Slot 0 carries
  // no state; the read logic never uses it because select 0 means DIN.
  logic [NREG-1:0][DW-1:0] rd_data;
  logic [NREG-1:0]         rd_busy;

  assign rd_data[0] = '0;
  assign rd_busy[0] = 1'b0;

  genvar gi;
  generate
    for (gi = 1; gi < NREG; gi++) begin : g_reg
      localparam logic [SW-1:0] IDX = SW'(gi);

      logic [DW-1:0] data_reg;
      logic          busy_reg;
      logic          wr_hit;
      logic          rsv_hit;

      // IDX is never 0, so a zero DSEL/RSEL can never match a register.
      assign wr_hit  = WEN && (DSEL == IDX);
      assign rsv_hit = RSV && (RSEL == IDX);

      always_ff @(posedge CLK) begin
        if (RST) begin
          data_reg <= '0;
          busy_reg <= 1'b0;
        end else begin
          if (wr_hit) begin
            data_reg <= RIN;
          end
          // A reserve in the same cycle as the write is for a later result,
          // so it takes priority over the write clearing the busy bit.
          if (rsv_hit) begin
            busy_reg <= 1'b1;
          end else if (wr_hit) begin
            busy_reg <= 1'b0;
          end
        end
      end

      assign rd_data[gi] = data_reg;
      assign rd_busy[gi] = busy_reg;
    end
  endgenerate

  // One read port: returns {busy, data}. Forwarding is purely combinational
  // and deliberately not gated by RST.
  function automatic logic [DW:0] read_port(
    input logic [SW-1:0]         sel,
    input logic [DW-1:0]         din,
    input logic                  wen,
    input logic [SW-1:0]         dsel,
    input logic [DW-1:0]         rin,
    input logic [NREG-1:0][DW-1:0] data,
    input logic [NREG-1:0]       busy
  );
    logic [DW:0] res;
    if (sel == '0) begin
      res = {1'b0, din};
    end else if (wen && (dsel == sel)) begin
      res = {1'b0, rin};
    end else begin
      res = {busy[sel], data[sel]};
    end
    return res;
  endfunction

  logic [DW:0] a_next;
  logic [DW:0] b_next;

  always_comb begin
    a_next = read_port(ASEL, DIN, WEN, DSEL, RIN, rd_data, rd_busy);
    b_next = read_port(BSEL, DIN, WEN, DSEL, RIN, rd_data, rd_busy);
  end

  assign ABUS  = a_next[DW-1:0];
  assign ABUSY = a_next[DW];
  assign BBUS  = b_next[DW-1:0];
  assign BBUSY = b_next[DW];
  assign STALL = ABUSY | BBUSY;

endmodule

// File: tb/tb_regfile_sb.sv
// -----------------------------------------------------------------------------
// tb_regfile_sb -- directed bench for regfile_sb
//
// Each step drives the inputs on the falling edge, pushes the expected bus
// values (from a small behavioural model) onto a scoreboard queue, samples the
// outputs 2 ns later, pops and compares, then lets the rising edge update both
// the DUT and the model. Spot checks against literal values follow key steps.
// -----------------------------------------------------------------------------
module tb_regfile_sb;

  localparam int DW   = 16;
  localparam int NREG = 8;
  localparam int SW   = 3;

  logic          CLK;
  logic          RST;
  logic [SW-1:0] ASEL, BSEL, DSEL, RSEL;
  logic [DW-1:0] DIN, RIN;
  logic          WEN, RSV;
  logic [DW-1:0] ABUS, BBUS;
  logic          ABUSY, BBUSY, STALL;

  regfile_sb #(.DW(DW), .NREG(NREG), .SW(SW)) dut (
    .CLK   (CLK),
    .RST   (RST),
    .ASEL  (ASEL),
    .BSEL  (BSEL),
    .DIN   (DIN),
    .DSEL  (DSEL),
    .WEN   (WEN),
    .RIN   (RIN),
    .RSV   (RSV),
    .RSEL  (RSEL),
    .ABUS  (ABUS),
    .BBUS  (BBUS),
    .ABUSY (ABUSY),
    .BBUSY (BBUSY),
    .STALL (STALL)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  typedef struct {
    string         tag;
    logic [DW-1:0] abus;
    logic [DW-1:0] bbus;
    logic          abusy;
    logic          bbusy;
    logic          stall;
  } exp_t;

  exp_t sb_q[$];

  int checks   = 0;
  int failures = 0;

  // Behavioural model of the register state
  logic [DW-1:0] m_r    [NREG];
  logic          m_busy [NREG];

  // Last sampled DUT outputs, for literal spot checks
  logic [DW-1:0] obs_abus, obs_bbus;
  logic          obs_abusy, obs_bbusy, obs_stall;

  task automatic check(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic model_read(input logic [SW-1:0] sel, input logic [DW-1:0] din,
                            input logic wen, input logic [SW-1:0] dsel,
                            input logic [DW-1:0] rin,
                            output logic [DW-1:0] data, output logic busy);
    if (sel == 0) begin
      data = din;
      busy = 1'b0;
    end else if (wen && dsel == sel) begin
      data = rin;
      busy = 1'b0;
    end else begin
      data = m_r[sel];
      busy = m_busy[sel];
    end
  endtask

  task automatic step(input string tag, input logic rst,
                      input logic [SW-1:0] asel, input logic [SW-1:0] bsel,
                      input logic [DW-1:0] din,
                      input logic wen, input logic [SW-1:0] dsel, input logic [DW-1:0] rin,
                      input logic rsv, input logic [SW-1:0] rsel);
    exp_t e;
    exp_t g;
    RST = rst; ASEL = asel; BSEL = bsel; DIN = din;
    WEN = wen; DSEL = dsel; RIN = rin; RSV = rsv; RSEL = rsel;
    e.tag = tag;
    model_read(asel, din, wen, dsel, rin, e.abus, e.abusy);
    model_read(bsel, din, wen, dsel, rin, e.bbus, e.bbusy);
    e.stall = e.abusy | e.bbusy;
    sb_q.push_back(e);
    #2;
    obs_abus  = ABUS;
    obs_bbus  = BBUS;
    obs_abusy = ABUSY;
    obs_bbusy = BBUSY;
    obs_stall = STALL;
    if (sb_q.size() == 0) begin
      checks++;
      failures++;
      $error("FAIL %s scoreboard empty observed=0 expected=1", tag);
    end else begin
      g = sb_q.pop_front();
      check({g.tag, ".abus"},  obs_abus,        g.abus);
      check({g.tag, ".bbus"},  obs_bbus,        g.bbus);
      check({g.tag, ".abusy"}, DW'(obs_abusy),  DW'(g.abusy));
      check({g.tag, ".bbusy"}, DW'(obs_bbusy),  DW'(g.bbusy));
      check({g.tag, ".stall"}, DW'(obs_stall),  DW'(g.stall));
    end
    $display("step %-10s rst=%0b a=%0d b=%0d din=%h wen=%0b d=%0d rin=%h rsv=%0b r=%0d -> abus=%h bbus=%h ab=%0b bb=%0b st=%0b",
             tag, rst, asel, bsel, din, wen, dsel, rin, rsv, rsel,
             obs_abus, obs_bbus, obs_abusy, obs_bbusy, obs_stall);
    @(posedge CLK);
    if (rst) begin
      for (int i = 0; i < NREG; i++) begin
        m_r[i]    = '0;
        m_busy[i] = 1'b0;
      end
    end else begin
      if (wen && dsel != 0) begin
        m_r[dsel]    = rin;
        m_busy[dsel] = 1'b0;
      end
      if (rsv && rsel != 0) m_busy[rsel] = 1'b1;
    end
    @(negedge CLK);
  endtask

  initial begin
    for (int i = 0; i < NREG; i++) begin
      m_r[i]    = '0;
      m_busy[i] = 1'b0;
    end
    RST = 1'b1; ASEL = '0; BSEL = '0; DIN = '0;
    WEN = 1'b0; DSEL = '0; RIN = '0; RSV = 1'b0; RSEL = '0;

    // 1: reset (write/reserve in the reset cycle must be ignored)
    step("reset", 1, 0, 0, 16'h0000, 1, 5, 16'hAAAA, 1, 3);
    step("t1", 0, 3, 0, 16'hBEEF, 0, 0, 16'h0000, 0, 0);
    check("t1_abus", obs_abus, 16'h0000);
    check("t1_bbus", obs_bbus, 16'hBEEF);
    check("t1_stall", DW'(obs_stall), 16'h0000);
    step("t1_r5", 0, 5, 3, 16'h0000, 0, 0, 16'h0000, 0, 0);
    check("t1_r5_abus", obs_abus, 16'h0000);

    // 2: forwarding, then the registered value
    step("t2_fwd", 0, 5, 5, 16'h0000, 1, 5, 16'h1234, 0, 0);
    check("t2_fwd_abus", obs_abus, 16'h1234);
    step("t2_reg", 0, 5, 0, 16'h0101, 0, 0, 16'h0000, 0, 0);
    check("t2_reg_abus", obs_abus, 16'h1234);

    // Fill every register with a distinct value, reading the previous one
    for (int i = 1; i < NREG; i++) begin
      step($sformatf("fill%0d", i), 0, SW'(i - 1), SW'(i), 16'h00D0,
           1, SW'(i), DW'(16'h1000 * i + i), 0, 0);
    end

    // 3: write to select 0 changes nothing
    step("t3_w0", 0, 0, 7, 16'hCAFE, 1, 0, 16'hFFFF, 0, 0);
    check("t3_w0_abus", obs_abus, 16'hCAFE);
    for (int i = 1; i < NREG; i++) begin
      step($sformatf("sweep%0d", i), 0, SW'(i), SW'(NREG - i), 16'h0000, 0, 0, 16'h0000, 0, 0);
      check($sformatf("sweep%0d_lit", i), obs_abus, DW'(16'h1000 * i + i));
    end

    // 4: reserve, stall, then write releases the operand
    step("t4_rsv", 0, 0, 0, 16'h0000, 0, 0, 16'h0000, 1, 2);
    step("t4_stall", 0, 2, 0, 16'h0000, 0, 0, 16'h0000, 0, 0);
    check("t4_abusy", DW'(obs_abusy), 16'h0001);
    check("t4_stall", DW'(obs_stall), 16'h0001);
    step("t4_wr", 0, 2, 0, 16'h0000, 1, 2, 16'h00AA, 0, 0);
    check("t4_wr_abus", obs_abus, 16'h00AA);
    check("t4_wr_abusy", DW'(obs_abusy), 16'h0000);
    step("t4_after", 0, 2, 2, 16'h0000, 0, 0, 16'h0000, 0, 0);
    check("t4_after_busy", DW'(obs_bbusy), 16'h0000);

    // 5: write and reserve same register -> data lands, reserve wins
    step("t5_rsv", 0, 0, 0, 16'h0000, 0, 0, 16'h0000, 1, 4);
    step("t5_both", 0, 0, 4, 16'h0000, 1, 4, 16'h0F0F, 1, 4);
    step("t5_chk", 0, 0, 4, 16'h0000, 0, 0, 16'h0000, 0, 0);
    check("t5_bbus", obs_bbus, 16'h0F0F);
    check("t5_bbusy", DW'(obs_bbusy), 16'h0001);
    // different registers in the same cycle, then re-reserve a busy one
    step("t5_diff", 0, 0, 0, 16'h0000, 1, 6, 16'h6666, 1, 7);
    step("t5_rsv2", 0, 6, 7, 16'h0000, 0, 0, 16'h0000, 1, 7);
    step("t5_dchk", 0, 6, 7, 16'h0000, 0, 0, 16'h0000, 0, 0);
    check("t5_dchk_bbusy", DW'(obs_bbusy), 16'h0001);
    // RSEL=0 reserve is a no-op
    step("t5_rsv0", 0, 0, 0, 16'h0000, 0, 0, 16'h0000, 1, 0);
    step("t5_r0chk", 0, 3, 1, 16'h0000, 0, 0, 16'h0000, 0, 0);

    // 6: reset mid-stall discards reservations and the concurrent write
    step("t6_wr", 0, 0, 0, 16'h0000, 1, 1, 16'h5555, 1, 1);
    step("t6_busy", 0, 1, 0, 16'h0000, 0, 0, 16'h0000, 0, 0);
    check("t6_busy_abus", obs_abus, 16'h5555);
    step("t6_rst", 1, 0, 0, 16'h0000, 1, 1, 16'h7777, 0, 0);
    step("t6_chk", 0, 1, 7, 16'h0000, 0, 0, 16'h0000, 0, 0);
    check("t6_abus", obs_abus, 16'h0000);
    check("t6_abusy", DW'(obs_abusy), 16'h0000);
    check("t6_bbusy", DW'(obs_bbusy), 16'h0000);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
